tc503_countdown_timer: RTL and testbench

- Two-digit (00–99) countdown timer with three quadrature rotary-encoder inputs, a multiplexed two-digit 7-segment display and three PWM outputs.
- enc0 sets the preset; enc1/enc2 set LED brightness on pwm1/pwm2; pwm0 is the "time expired" alarm.
- Top-level TinyTapeout user tile; pad-facing ports follow the standard tile pinout.

---
 rtl/tc503_countdown_timer.sv | 168 ++++++++++++++++
 tb/tb_tc503_countdown_timer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/tc503_countdown_timer.sv
// Two-digit BCD countdown timer: encoder-set preset, muxed 7-segment display,
// two brightness PWMs and a time-expired alarm PWM.
module tc503_countdown_timer #(
    parameter int unsigned TICK_DIV = 10_000_000,
    parameter int unsigned MUX_DIV  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MUX_W  = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
    localparam logic [MUX_W-1:0]  MUX_MAX  = MUX_W'(MUX_DIV - 1);

    logic [7:0]        sync1, sync2, hist;
    logic [2:0]        step, dir_down;
    logic              run, tick, zero;
    logic [TICK_W-1:0] presc;
    logic [MUX_W-1:0]  mux_cnt;
    logic              dis0_ctrl;
    logic [3:0]        tens, ones, tens_n, ones_n;
    logic [3:0]        l1, l2;
    logic [7:0]        pc;
    logic [2:0]        pwm, pwm_n;
    logic [3:0]        digit;

    // Saturating 0..15 level adjust for the brightness encoders.
    function automatic logic [3:0] level_step(input logic [3:0] lvl, input logic stp,
                                              input logic dn);
        logic [3:0] r;
        r = lvl;
        if (stp) begin
            if (dn) begin
                if (lvl != 4'd0) r = lvl - 4'd1;
            end else begin
                if (lvl != 4'd15) r = lvl + 4'd1;
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Input synchronizer plus one history stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 8'h00;
            sync2 <= 8'h00;
            hist  <= 8'h00;
        end else begin
            sync1 <= ui_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            step[i]     = sync2[2*i] & ~hist[2*i];
            dir_down[i] = sync2[2*i+1];
        end
    end

    assign run  = sync2[7];
    assign tick = run && (presc == TICK_MAX);
    assign zero = (tens == 4'd0) && (ones == 4'd0);

    // A countdown tick takes priority; enc0 only edits the preset while stopped.
    always_comb begin
        tens_n = tens;
        ones_n = ones;
        if (tick) begin
            if (!zero) begin
                if (ones == 4'd0) begin
                    ones_n = 4'd9;
                    tens_n = tens - 4'd1;
                end else begin
                    ones_n = ones - 4'd1;
                end
            end
        end else if (!run && step[0]) begin
            if (dir_down[0]) begin
                if (!zero) begin
                    if (ones == 4'd0) begin
                        ones_n = 4'd9;
                        tens_n = tens - 4'd1;
                    end else begin
                        ones_n = ones - 4'd1;
                    end
                end
            end else if (!((tens == 4'd9) && (ones == 4'd9))) begin
                if (ones == 4'd9) begin
                    ones_n = 4'd0;
                    tens_n = tens + 4'd1;
                end else begin
                    ones_n = ones + 4'd1;
                end
            end
        end
    end

    always_comb begin
        pwm_n[0] = run && zero && pc[7];
        pwm_n[1] = (pc[7:4] < l1);
        pwm_n[2] = (pc[7:4] < l2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            mux_cnt   <= '0;
            dis0_ctrl <= 1'b0;
            tens      <= 4'd0;
            ones      <= 4'd0;
            l1        <= 4'd0;
            l2        <= 4'd0;
            pc        <= 8'd0;
            pwm       <= 3'b000;
        end else begin
            presc <= (!run || tick) ? '0 : presc + TICK_W'(1);
            if (mux_cnt == MUX_MAX) begin
                mux_cnt   <= '0;
                dis0_ctrl <= ~dis0_ctrl;
            end else begin
                mux_cnt <= mux_cnt + MUX_W'(1);
            end
            tens <= tens_n;
            ones <= ones_n;
            l1   <= level_step(l1, step[1], dir_down[1]);
            l2   <= level_step(l2, step[2], dir_down[2]);
            pc   <= pc + 8'd1;
            pwm  <= pwm_n;
        end
    end

    // Segments follow the registered digit select with no extra latency.
    assign digit   = dis0_ctrl ? tens : ones;
    assign uo_out  = {dis0_ctrl, seg7(digit)};
    assign uio_out = {5'b00000, pwm};
    assign uio_oe  = 8'b0000_0111;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in, sync2[6], hist[7:6], hist[5], hist[3], hist[1]};

endmodule

// File: tb/tb_tc503_countdown_timer.sv
// Directed bench for tc503_countdown_timer with TICK_DIV=10, MUX_DIV=4.
module tb_tc503_countdown_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ui_in, uo_out, uio_out, uio_oe;
    logic [2:0] enc_a, enc_b;
    logic       run_in;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int up;
        int down;
        int run_cyc;
        int exp;
    } vec_t;

    vec_t       vecs[16];
    logic [6:0] seg_tab[10];

    assign ui_in = {run_in, 1'b0, enc_b[2], enc_a[2], enc_b[1], enc_a[1], enc_b[0], enc_a[0]};

    tc503_countdown_timer #(.TICK_DIV(10), .MUX_DIV(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (1'b1),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (8'h00),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One encoder detent on every encoder selected in mask, all in the same direction.
    task automatic enc_step(input logic [2:0] mask, input logic down);
        for (int i = 0; i < 3; i++) if (mask[i]) enc_b[i] = down;
        repeat (2) tick();
        enc_a = enc_a | mask;
        repeat (4) tick();
        enc_a = enc_a & ~mask;
        repeat (4) tick();
    endtask

    task automatic run_for(input int cyc);
        if (cyc > 0) begin
            run_in = 1'b1;
            repeat (cyc) tick();
            run_in = 1'b0;
            repeat (6) tick();
        end
    endtask

    task automatic read_digits(input string name, input int exp);
        int         n;
        logic [6:0] s_ones, s_tens;
        logic [6:0] e_ones, e_tens;
        s_ones = 7'h00;
        s_tens = 7'h00;
        e_ones = seg_tab[exp % 10];
        e_tens = seg_tab[exp / 10];
        n = 0;
        while (uo_out[7] != 1'b0 && n < 20) begin tick(); n++; end
        if (n >= 20) check({name, "_timeout0"}, 1, 0);
        s_ones = uo_out[6:0];
        n = 0;
        while (uo_out[7] != 1'b1 && n < 20) begin tick(); n++; end
        if (n >= 20) check({name, "_timeout1"}, 1, 0);
        s_tens = uo_out[6:0];
        check({name, "_ones"}, int'(s_ones), int'(e_ones));
        check({name, "_tens"}, int'(s_tens), int'(e_tens));
    endtask

    task automatic count_high(input int idx, output int cnt);
        cnt = 0;
        repeat (256) begin
            tick();
            cnt += int'(uio_out[idx]);
        end
    endtask

    initial begin
        int c;
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        //          up  down run  exp
        vecs[0]  = '{12,  0,   0, 12};
        vecs[1]  = '{ 0,  3,   0,  9};
        vecs[2]  = '{ 0, 12,   0,  0};
        vecs[3]  = '{ 0,  3,   0,  0};
        vecs[4]  = '{99,  0,   0, 99};
        vecs[5]  = '{ 1,  0,   0, 99};
        vecs[6]  = '{ 0, 89,   0, 10};
        vecs[7]  = '{ 0,  0,   9, 10};
        vecs[8]  = '{ 0,  0,  10,  9};
        vecs[9]  = '{ 0,  0,   9,  9};
        vecs[10] = '{ 0,  0,   5,  9};
        vecs[11] = '{ 0,  0,   5,  9};
        vecs[12] = '{ 0,  0,  10,  8};
        vecs[13] = '{ 0,  5,   0,  3};
        vecs[14] = '{ 0,  0,  30,  0};
        vecs[15] = '{ 0,  0,  15,  0};

        enc_a  = 3'b000;
        enc_b  = 3'b000;
        run_in = 1'b0;
        rst    = 1'b1;
        repeat (3) tick();
        check("reset_uo_out", int'(uo_out), 8'h3F);
        check("reset_uio_out", int'(uio_out), 0);
        check("reset_uio_oe", int'(uio_oe), 8'h07);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 16; v++) begin
            repeat (vecs[v].up) enc_step(3'b001, 1'b0);
            repeat (vecs[v].down) enc_step(3'b001, 1'b1);
            run_for(vecs[v].run_cyc);
            read_digits($sformatf("vec%0d", v), vecs[v].exp);
        end

        // Alarm at 00 while running; enc0 must be ignored.
        run_in = 1'b1;
        repeat (4) tick();
        enc_step(3'b001, 1'b0);
        count_high(0, c);
        check("alarm_pwm0_duty", c, 128);
        count_high(1, c);
        check("pwm1_off_at_zero_level", c, 0);
        read_digits("alarm_value", 0);
        run_in = 1'b0;
        repeat (6) tick();
        count_high(0, c);
        check("alarm_off_when_stopped", c, 0);

        // Simultaneous steps on enc1 and enc2.
        repeat (8) enc_step(3'b110, 1'b0);
        count_high(1, c);
        check("pwm1_level8", c, 128);
        count_high(2, c);
        check("pwm2_level8", c, 128);
        repeat (12) enc_step(3'b100, 1'b0);
        count_high(2, c);
        check("pwm2_level15_sat", c, 240);
        repeat (3) enc_step(3'b010, 1'b1);
        count_high(1, c);
        check("pwm1_level5", c, 80);
        check("uio_oe_const", int'(uio_oe), 8'h07);

        // Reset in the middle of a countdown.
        repeat (5) enc_step(3'b001, 1'b0);
        read_digits("preset5", 5);
        run_in = 1'b1;
        repeat (15) tick();
        rst = 1'b1;
        tick();
        check("midrst_uo_out", int'(uo_out), 8'h3F);
        check("midrst_uio_out", int'(uio_out), 0);
        run_in = 1'b0;
        rst    = 1'b0;
        repeat (6) tick();
        read_digits("midrst_value", 0);
        count_high(2, c);
        check("midrst_pwm2_level", c, 0);
        count_high(1, c);
        check("midrst_pwm1_level", c, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

endmodule
